mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have a single clock domain and a synchronous, active-high reset.
REQ-002 Port clk: input, 1 bit, rising-edge clock.
REQ-003 Port rst: input, 1 bit, synchronous active-high reset.
REQ-004 Ports req0, req1: input, 1 bit each, operation request per requester; held high until that requester's ack.
REQ-005 Ports a0, b0, a1, b1: input, 16 bits each, operands; held stable while the matching req is high.
REQ-006 Ports ack0, ack1: output, 1 bit each, one-cycle completion pulse.
REQ-007 Port result: output, 16 bits, product of the last completed operation.
REQ-008 Ports dp_lda, dp_ldb, dp_ldp, dp_clrp, dp_decb: output, 1 bit each, strobes to the shared repeated-addition multiplier datapath.
REQ-009 Port dp_data: output, 16 bits, datapath data_in.
REQ-010 Port dp_eqz: input, 1 bit, datapath B-register-equals-zero flag.
REQ-011 Port dp_y: input, 16 bits, datapath product register.

Function
REQ-012 State machine states SHALL be IDLE, LOAD_A, LOAD_B, ACC, DONE.
REQ-013 IDLE, no req high: SHALL stay IDLE with all strobes 0.
REQ-014 IDLE, any req high: SHALL grant one requester per REQ-015, latch its index, and go to LOAD_A.
REQ-015 Both req high in IDLE: SHALL grant the requester not served last (round-robin); single req is granted regardless of the pointer.
REQ-016 LOAD_A: dp_data = granted a, dp_lda = 1; next state LOAD_B.
REQ-017 LOAD_B: dp_data = granted b, dp_ldb = 1, dp_clrp = 1; next state ACC.
REQ-018 ACC with dp_eqz = 0: dp_ldp = 1, dp_decb = 1; stay in ACC.
REQ-019 ACC with dp_eqz = 1: no strobes; capture dp_y into result; go to DONE.
REQ-020 DONE: the granted ack SHALL be 1 for exactly one cycle; update the round-robin pointer to the granted index; go to IDLE.
REQ-021 Latency: DONE SHALL be entered b+3 edges after the edge that samples req in IDLE, so ACC occupies b+1 cycles.
REQ-022 dp_data SHALL be 0 outside LOAD_A and LOAD_B; at most one of dp_lda and dp_ldb SHALL be high in any cycle.
REQ-023 Arithmetic: the product SHALL be modulo 2^16; overflow is silently truncated by the datapath, and the block does no overflow detection.
REQ-024 A req that drops mid-operation SHALL be ignored: the operation completes and ack still pulses.
REQ-025 A req held high during its own DONE cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-026 result SHALL hold its value until the next capture.

Reset
REQ-027 rst SHALL force IDLE, all strobes 0, ack0/ack1 0, result 0, dp_data 0, and the round-robin pointer to "last served = 1", so requester 0 wins the first tie.
REQ-028 rst mid-operation SHALL abort without an ack; a still-high req SHALL be re-served from LOAD_A after reset deasserts.

Configuration
REQ-029 Macro MUL_ARB_ZERO_BYPASS_EN defined: in IDLE, if the granted a or b is 0, the block SHALL go directly to DONE with result = 0 and issue no datapath strobes, giving a 1-edge latency to DONE.
REQ-030 MUL_ARB_ZERO_BYPASS_EN undefined: zero operands SHALL take the normal path of REQ-016 to REQ-019 (b = 0 gives ACC for 1 cycle; a = 0 iterates b times).

Structure
REQ-031 Package mul_arb_pkg SHALL hold the state enumeration, the DATA_W = 16 constant, and the requester-count constant.
REQ-032 Sub-module mul_arb_rr SHALL implement the 2-way round-robin grant and pointer; the FSM, result register and datapath drive SHALL stay in mul_arbiter.

Verification
REQ-033 The bench SHALL include a behavioural repeated-addition datapath model and cover the following scenarios.
REQ-034 req0 with a0 = 17, b0 = 5 -> ack0 pulses 8 edges after sampling, result = 85, dp_ldp high for exactly 5 cycles.
REQ-035 req0 and req1 raised in the same cycle after reset (a0 = 3, b0 = 4; a1 = 6, b1 = 2) -> ack0 first with result 12, then ack1 with result 12, and ack1 is never asserted before ack0.
REQ-036 Both requesters held high continuously -> acks alternate 0, 1, 0, 1 over 4 operations.
REQ-037 a0 = 9, b0 = 0 -> without MUL_ARB_ZERO_BYPASS_EN, result 0 after 3 edges; with it, result 0 after 1 edge and no dp_lda.
REQ-038 rst asserted during ACC with a0 = 300, b0 = 300 -> no ack0, all outputs 0 next cycle; req0 still high -> re-served to completion with result 24464 (90000 mod 65536).

Source files
------------

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared constants and FSM state type for the multiplier arbiter
package mul_arb_pkg;
  localparam int DATA_W = 16;
  localparam int REQ_N = 2;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ACC, DONE} state_e;
endpackage

// File: rtl/mul_arb_rr.sv
// mul_arb_rr: two-way round-robin grant with a last-served pointer
module mul_arb_rr import mul_arb_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  input  logic             upd,
  input  logic             upd_idx,
  output logic             gnt_idx
);
  logic last_q, last_d;
  // a tie goes to the requester not served last; a lone request always wins
  always_comb begin
    gnt_idx = (&req) ? ~last_q : req[1];
    last_d = upd ? upd_idx : last_q;
  end
  // pointer resets to "last served = 1" so requester 0 wins the first tie
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : last_d;
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one repeated-addition multiplier between two requesters (optional MUL_ARB_ZERO_BYPASS_EN skips the datapath for zero operands)
module mul_arbiter import mul_arb_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] result,
  output logic              dp_lda,
  output logic              dp_ldb,
  output logic              dp_ldp,
  output logic              dp_clrp,
  output logic              dp_decb,
  output logic [DATA_W-1:0] dp_data,
  input  logic              dp_eqz,
  input  logic [DATA_W-1:0] dp_y
);
  state_e state_q, state_d;
  logic gnt_q, gnt_d, rr_gnt;
  logic [DATA_W-1:0] result_q, result_d, ga, gb;
  logic [REQ_N-1:0] req;
  assign req = {req1, req0};
  assign ga = gnt_q ? a1 : a0;
  assign gb = gnt_q ? b1 : b0;
  assign result = result_q;
`ifdef MUL_ARB_ZERO_BYPASS_EN
  logic [DATA_W-1:0] na, nb;
  assign na = rr_gnt ? a1 : a0;
  assign nb = rr_gnt ? b1 : b0;
`endif
  mul_arb_rr u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .upd     (state_q == DONE),
    .upd_idx (gnt_q),
    .gnt_idx (rr_gnt)
  );
  // next state, datapath strobes and ack; strobes are decoded from the current state
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    result_d = result_q;
    dp_lda = 1'b0;
    dp_ldb = 1'b0;
    dp_ldp = 1'b0;
    dp_clrp = 1'b0;
    dp_decb = 1'b0;
    dp_data = '0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        gnt_d = rr_gnt;
        state_d = LOAD_A;
`ifdef MUL_ARB_ZERO_BYPASS_EN
        if (na == '0 || nb == '0) begin
          state_d = DONE;
          result_d = '0;
        end
`endif
      end
      LOAD_A: begin
        dp_data = ga;
        dp_lda = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        dp_data = gb;
        dp_ldb = 1'b1;
        dp_clrp = 1'b1;
        state_d = ACC;
      end
      ACC: if (dp_eqz) begin
        result_d = dp_y;
        state_d = DONE;
      end else begin
        dp_ldp = 1'b1;
        dp_decb = 1'b1;
      end
      DONE: begin
        ack0 = ~gnt_q;
        ack1 = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, granted index and result registers
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    gnt_q <= rst ? 1'b0 : gnt_d;
    result_q <= rst ? '0 : result_d;
  end
endmodule
